ad7276_spi_capture: RTL and testbench



---
 rtl/ad7276_pkg.sv | 26 ++
 rtl/ad7276_sample_timer.sv | 43 ++++
 rtl/ad7276_spi_capture.sv | 191 +++++++++++++++++++
 tb/tb_ad7276_spi_capture.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ad7276_pkg.sv
// ad7276_pkg: shared types and defaults for the AD7276 serial capture front end.
//   state_t            capture FSM states (IDLE, SHIFT, TAIL, QUIET)
//   *_DEF              default frame geometry
//   cnt_width()        width needed for a counter that holds 0..n
//   BIT_CNT_W          bit-counter width for the default frame length
package ad7276_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      TAIL  = 2'd2,
      QUIET = 2'd3
   } state_t;

   localparam int unsigned FRAME_BITS_DEF     = 16;
   localparam int unsigned LEAD_ZEROS_DEF     = 2;
   localparam int unsigned OUT_DATA_WIDTH_DEF = 12;

   // Bits needed to represent values 0..n (minimum 1).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

   localparam int unsigned BIT_CNT_W = cnt_width(FRAME_BITS_DEF);

endpackage

// File: rtl/ad7276_sample_timer.sv
// ad7276_sample_timer: conversion pacing timer.
//   clk, rst (async, active low)
//   enable         level-sensitive run enable; low holds the counter at reload
//   sample_period  clk cycles between starts; 0 = continuous requests
//   start_req_c    combinational start request for the capture FSM
module ad7276_sample_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [31:0] sample_period,
   output logic        start_req_c
);

   logic [31:0] cnt;
   logic [31:0] cnt_nxt;
   logic [31:0] reload;

   // sample_period is re-read only at reload, so a change applies next period.
   assign reload = (sample_period == 32'd0) ? 32'd0 : sample_period - 32'd1;

   // Request on terminal count, or every cycle in free-run mode.
   always_comb begin
      start_req_c = enable && ((sample_period == 32'd0) || (cnt == 32'd0));
   end

   always_comb begin
      cnt_nxt = cnt;
      if (!enable || (cnt == 32'd0)) begin
         cnt_nxt = reload;
      end else begin
         cnt_nxt = cnt - 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= 32'd0;
      end else begin
         cnt <= cnt_nxt;
      end
   end

endmodule

// File: rtl/ad7276_spi_capture.sv
// ad7276_spi_capture: AD7276 serial front end. Paces conversions, drives
// CS/SCLK, shifts in one FRAME_BITS frame and emits one sample per frame.
//   clk, rst (async, active low)
//   enable, sample_period     conversion pacing controls
//   spi_cs_n, spi_sclk        ADC chip select / serial clock (both idle high)
//   spi_sdata                 ADC serial data, sampled on the sclk 0->1 clk edge
//   out_data, out_data_valid  captured sample and its one-cycle strobe
//   busy                      high whenever the FSM is not in IDLE
//   overrun                   sticky: a start arrived while a frame was active
//   frame_err                 one-cycle strobe on a frame with a nonzero lead bit
// Build option: AD7276_FRAME_CHECK_EN enables the leading-zero frame check;
// without it frame_err stays 0 and every frame produces out_data_valid.
module ad7276_spi_capture
   import ad7276_pkg::*;
#(
   parameter int unsigned OUT_DATA_WIDTH = OUT_DATA_WIDTH_DEF,
   parameter int unsigned CLK_DIV        = 2,
   parameter int unsigned FRAME_BITS     = FRAME_BITS_DEF,
   parameter int unsigned LEAD_ZEROS     = LEAD_ZEROS_DEF,
   parameter int unsigned QUIET_CYCLES   = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic [31:0]               sample_period,
   output logic                      spi_cs_n,
   output logic                      spi_sclk,
   input  logic                      spi_sdata,
   output logic [OUT_DATA_WIDTH-1:0] out_data,
   output logic                      out_data_valid,
   output logic                      busy,
   output logic                      overrun,
   output logic                      frame_err
);

   localparam int unsigned DIV_W  = cnt_width(CLK_DIV);
   localparam int unsigned BIT_W  = cnt_width(FRAME_BITS);
   localparam int unsigned Q_LAST = (QUIET_CYCLES > 1) ? QUIET_CYCLES - 1 : 1;
   localparam int unsigned Q_W    = cnt_width(Q_LAST);
   localparam int unsigned MSB_POS = FRAME_BITS - 1 - LEAD_ZEROS;

   state_t                    state, state_nxt;
   logic [DIV_W-1:0]          div_cnt, div_nxt;
   logic [BIT_W-1:0]          bit_cnt, bit_nxt;
   logic [Q_W-1:0]            q_cnt, q_nxt;
   logic [FRAME_BITS-1:0]     shreg, sh_nxt;
   logic                      cs_nxt, sclk_nxt;
   logic [OUT_DATA_WIDTH-1:0] data_nxt;
   logic                      valid_nxt, ferr_nxt, ovr_nxt;
   logic                      start_req_c;
`ifdef AD7276_FRAME_CHECK_EN
   logic                      lead_bad;
`endif

   ad7276_sample_timer u_timer (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .sample_period (sample_period),
      .start_req_c   (start_req_c)
   );

   // Next-state and next-output logic for the capture FSM.
   always_comb begin
      state_nxt = state;
      cs_nxt    = spi_cs_n;
      sclk_nxt  = spi_sclk;
      div_nxt   = div_cnt;
      bit_nxt   = bit_cnt;
      q_nxt     = q_cnt;
      sh_nxt    = shreg;
      data_nxt  = out_data;
      valid_nxt = 1'b0;
      ferr_nxt  = 1'b0;
      ovr_nxt   = overrun;
`ifdef AD7276_FRAME_CHECK_EN
      lead_bad  = 1'b0;
      for (int unsigned i = 0; i < LEAD_ZEROS; i++) begin
         lead_bad = lead_bad | shreg[FRAME_BITS-1-i];
      end
`endif

      // Free-run requests are expected to land mid-frame, so they never count.
      if (!enable) begin
         ovr_nxt = 1'b0;
      end else if (start_req_c && (state != IDLE) && (sample_period != 32'd0)) begin
         ovr_nxt = 1'b1;
      end

      case (state)
         IDLE: begin
            if (start_req_c) begin
               state_nxt = SHIFT;
               cs_nxt    = 1'b0;
               sclk_nxt  = 1'b1;
               div_nxt   = '0;
               bit_nxt   = '0;
            end
         end

         SHIFT: begin
            if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
               div_nxt  = '0;
               sclk_nxt = ~spi_sclk;
               // Sample on the edge that drives sclk high.
               if (!spi_sclk) begin
                  sh_nxt  = (shreg << 1) | FRAME_BITS'(spi_sdata);
                  bit_nxt = bit_cnt + BIT_W'(1);
                  if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
                     state_nxt = TAIL;
                  end
               end
            end else begin
               div_nxt = div_cnt + DIV_W'(1);
            end
         end

         TAIL: begin
            // First TAIL cycle: the full frame is in shreg.
            if (div_cnt == '0) begin
`ifdef AD7276_FRAME_CHECK_EN
               if (lead_bad) begin
                  ferr_nxt = 1'b1;
               end else begin
                  valid_nxt = 1'b1;
                  data_nxt  = shreg[MSB_POS -: OUT_DATA_WIDTH];
               end
`else
               valid_nxt = 1'b1;
               data_nxt  = shreg[MSB_POS -: OUT_DATA_WIDTH];
`endif
            end
            if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
               cs_nxt    = 1'b1;
               state_nxt = QUIET;
               div_nxt   = '0;
               q_nxt     = Q_W'(1);
            end else begin
               div_nxt = div_cnt + DIV_W'(1);
            end
         end

         QUIET: begin
            // The IDLE cycle that follows also keeps cs_n high, so it counts.
            if (q_cnt >= Q_W'(Q_LAST)) begin
               state_nxt = IDLE;
            end else begin
               q_nxt = q_cnt + Q_W'(1);
            end
         end

         default: begin
            state_nxt = IDLE;
            cs_nxt    = 1'b1;
            sclk_nxt  = 1'b1;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         spi_cs_n       <= 1'b1;
         spi_sclk       <= 1'b1;
         div_cnt        <= '0;
         bit_cnt        <= '0;
         q_cnt          <= '0;
         shreg          <= '0;
         out_data       <= '0;
         out_data_valid <= 1'b0;
         frame_err      <= 1'b0;
         overrun        <= 1'b0;
         busy           <= 1'b0;
      end else begin
         state          <= state_nxt;
         spi_cs_n       <= cs_nxt;
         spi_sclk       <= sclk_nxt;
         div_cnt        <= div_nxt;
         bit_cnt        <= bit_nxt;
         q_cnt          <= q_nxt;
         shreg          <= sh_nxt;
         out_data       <= data_nxt;
         out_data_valid <= valid_nxt;
         frame_err      <= ferr_nxt;
         overrun        <= ovr_nxt;
         busy           <= (state_nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_ad7276_spi_capture.sv
// tb_ad7276_spi_capture: scoreboard bench for ad7276_spi_capture (default
// parameters). An ADC model serves random frames and queues the expected
// sample at each cs_n fall; a monitor pops and compares on every output strobe
// and checks frame timing. Honours AD7276_FRAME_CHECK_EN like the design.
module tb_ad7276_spi_capture;

   typedef struct packed {
      logic [11:0] data;
      logic        bad;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic [31:0] sample_period = 32'd200;
   logic        spi_cs_n, spi_sclk;
   logic        spi_sdata = 1'b0;
   logic [11:0] out_data;
   logic        out_data_valid, busy, overrun, frame_err;

   int          checks = 0;
   int          passes = 0;

   exp_t        sb[$];
   logic [15:0] cur_word = 16'h0;
   logic [15:0] force_word = 16'h0;
   logic        force_valid = 1'b0;
   logic        allow_bad = 1'b0;
   logic [11:0] last_good = 12'h0;

   logic        prev_cs = 1'b1, prev_sclk = 1'b1;
   int          rise_cnt = 0, low_cnt = 0, high_cnt = 0, sp_cnt = 0, lat = 0;
   int          n_falls = 0, ev_seen = 0;
   int          exp_spacing = 0;
   logic        gap_check = 1'b0;
   logic        first_fall = 1'b1;

   ad7276_spi_capture dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .sample_period  (sample_period),
      .spi_cs_n       (spi_cs_n),
      .spi_sclk       (spi_sclk),
      .spi_sdata      (spi_sdata),
      .out_data       (out_data),
      .out_data_valid (out_data_valid),
      .busy           (busy),
      .overrun        (overrun),
      .frame_err      (frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // ADC model, frame-timing checks and scoreboard monitor.
   always @(negedge clk) begin
      logic fell, rose;
      logic [31:0] d;
      logic [1:0]  lead;
      exp_t        e;
      if (!rst) begin
         prev_cs = 1'b1; prev_sclk = 1'b1; rise_cnt = 0; low_cnt = 0; spi_sdata = 1'b0;
      end else begin
         fell = prev_cs && !spi_cs_n;
         rose = !prev_cs && spi_cs_n;
         sp_cnt++;
         lat++;
         if (fell) begin
            n_falls++;
            if (!first_fall && exp_spacing != 0) chk("frame_spacing", 32'(sp_cnt), 32'(exp_spacing));
            if (!first_fall && gap_check) chk("cs_high_gap", 32'(high_cnt), 32'd4);
            first_fall = 1'b0; sp_cnt = 0; lat = 0; low_cnt = 1; rise_cnt = 0;
            if (force_valid) begin
               cur_word = force_word; force_valid = 1'b0;
            end else begin
               d = $urandom;
               lead = (allow_bad && $urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
               cur_word = {lead, d[11:0], d[13:12]};
            end
            // Reference: 12-bit sample after the two lead bits; bad if a lead bit is set.
            e.data = 12'((cur_word >> 2) & 16'h0FFF);
            e.bad  = ((cur_word >> 14) != 16'd0);
            sb.push_back(e);
         end else if (!spi_cs_n) begin
            low_cnt++;
         end
         if (spi_cs_n) high_cnt = rose ? 1 : high_cnt + 1;
         if (!spi_cs_n && !fell && spi_sclk && !prev_sclk) rise_cnt++;
         if (rose) begin
            chk("cs_low_cycles", 32'(low_cnt), 32'd66);
            chk("sclk_rises", 32'(rise_cnt), 32'd16);
         end
         if (out_data_valid || frame_err) begin
            ev_seen++;
            chk("valid_latency", 32'(lat), 32'd65);
            chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
`ifdef AD7276_FRAME_CHECK_EN
               if (out_data_valid) begin
                  chk("good_frame_kind", 32'(e.bad), 32'd0);
                  chk("out_data", 32'(out_data), 32'(e.data));
                  last_good = e.data;
               end else begin
                  chk("bad_frame_kind", 32'(e.bad), 32'd1);
                  chk("data_held_on_err", 32'(out_data), 32'(last_good));
               end
`else
               chk("frame_err_tied_low", 32'(frame_err), 32'd0);
               chk("out_data", 32'(out_data), 32'(e.data));
               last_good = e.data;
`endif
            end
         end
         prev_cs = spi_cs_n;
         prev_sclk = spi_sclk;
         spi_sdata = (!spi_cs_n && rise_cnt < 16) ? cur_word[4'(15 - rise_cnt)] : 1'b0;
      end
   end

   task automatic wait_events(input int n, input int budget, input string name);
      int target = ev_seen + n;
      int c = 0;
      while (ev_seen < target && c < budget) begin @(negedge clk); c++; end
      chk(name, 32'(ev_seen >= target), 32'd1);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int c = 0;
      while (busy && c < budget) begin @(negedge clk); c++; end
      chk(name, 32'(busy), 32'd0);
   endtask

   task automatic start_run(input logic [31:0] per, input int spacing, input logic gap, input logic bad);
      sample_period = per; exp_spacing = spacing; gap_check = gap;
      allow_bad = bad; first_fall = 1'b1;
      enable = 1'b1;
   endtask

   initial begin
      int k, c, fl, vs;
      logic ps;
      repeat (4) @(negedge clk);
      chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
      chk("rst_sclk", 32'(spi_sclk), 32'd1);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_valid", 32'(out_data_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_frame_err", 32'(frame_err), 32'd0);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // 1: fixed first sample, then random, period 200.
      force_word = 16'h2970; force_valid = 1'b1;
      start_run(32'd200, 200, 1'b0, 1'b0);
      wait_events(1, 400, "t1_first_valid");
      chk("t1_data_a5c", 32'(out_data), 32'h0A5C);
      wait_events(3, 800, "t1_more_valids");
      chk("t1_overrun", 32'(overrun), 32'd0);
      enable = 1'b0;
      wait_idle(200, "t1_idle");

      // 2: free-run, back-to-back frames with a 4-cycle gap.
      start_run(32'd0, 70, 1'b1, 1'b0);
      wait_events(5, 600, "t2_valids");
      chk("t2_overrun", 32'(overrun), 32'd0);
      enable = 1'b0;
      wait_idle(200, "t2_idle");

      // 3: period shorter than a frame -> overrun, every second request served.
      start_run(32'd40, 80, 1'b0, 1'b0);
      wait_events(3, 400, "t3_valids");
      chk("t3_overrun_set", 32'(overrun), 32'd1);
      enable = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("t3_overrun_cleared", 32'(overrun), 32'd0);
      wait_idle(200, "t3_idle");

      // 4: reset at the 7th sclk rising edge.
      start_run(32'd200, 0, 1'b0, 1'b0);
      c = 0;
      do begin @(posedge clk); #1; c++; end while (spi_cs_n && c < 400);
      chk("t4_frame_started", 32'(spi_cs_n), 32'd0);
      k = 0; ps = spi_sclk; c = 0;
      while (k < 7 && c < 100) begin
         @(posedge clk); #1; c++;
         if (spi_sclk && !ps) k++;
         ps = spi_sclk;
      end
      vs = ev_seen;
      rst = 1'b0;
      #1;
      chk("t4_cs_n_abort", 32'(spi_cs_n), 32'd1);
      chk("t4_sclk_abort", 32'(spi_sclk), 32'd1);
      chk("t4_busy_abort", 32'(busy), 32'd0);
      sb.delete();
      last_good = 12'h0;
      repeat (3) @(negedge clk);
      chk("t4_no_valid_in_reset", 32'(ev_seen), 32'(vs));
      chk("t4_out_data_reset", 32'(out_data), 32'd0);
      first_fall = 1'b1;
      rst = 1'b1;
      wait_events(1, 400, "t4_after_reset_valid");
      enable = 1'b0;
      wait_idle(200, "t4_idle");

      // 5: random bad lead bits, first frame forced bad (01).
      force_word = 16'h448E; force_valid = 1'b1;
      start_run(32'd100, 100, 1'b0, 1'b1);
      wait_events(8, 1200, "t5_events");
      enable = 1'b0;
      wait_idle(200, "t5_idle");
      allow_bad = 1'b0;

      // 6: enable drops mid-frame; the frame still completes, then silence.
      start_run(32'd200, 0, 1'b0, 1'b0);
      c = 0;
      while (spi_cs_n && c < 400) begin @(negedge clk); c++; end
      repeat (20) @(negedge clk);
      vs = ev_seen;
      enable = 1'b0;
      wait_events(1, 200, "t6_sample_delivered");
      wait_idle(20, "t6_busy_falls");
      fl = n_falls;
      repeat (300) @(negedge clk);
      chk("t6_no_new_frames", 32'(n_falls), 32'(fl));
      chk("t6_one_event", 32'(ev_seen - vs), 32'd1);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
